control_unit: RTL and testbench

- Multicycle FSM that sequences the MIPS datapath.
- Consumes the instruction fields and ALU flags the datapath produces, and drives every write enable and mux select the datapath consumes.
- Sits beside the datapath top and is instantiated in the Unit_Control slot.
- Covers the instruction subset below plus the overflow and invalid-opcode exceptions.

---
 rtl/control_pkg.sv | 88 ++++++++
 rtl/control_decode.sv | 43 ++++
 rtl/control_unit.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// ============================================================================
// Module      : control_pkg
// Description : Shared encodings for the multicycle MIPS control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_pkg;

    typedef enum logic [4:0] {
        ST_RESET, ST_FETCH, ST_DECODE,
        ST_EX_ADD, ST_EX_SUB, ST_EX_AND, ST_EX_SLT, ST_EX_ADDI,
        ST_WB_RD, ST_WB_SLT, ST_WB_RT, ST_LUI,
        ST_SH_LD, ST_SH_SLL, ST_SH_SRL, ST_SH_SRA, ST_WB_SH,
        ST_JR, ST_BEQ, ST_BNE, ST_J, ST_JAL_LINK, ST_JAL_JUMP,
        ST_ADDR, ST_MEMRD, ST_WB_LW, ST_WB_LB, ST_MEM_SW, ST_MEM_SB,
        ST_EXC_SAVE, ST_EXC_READ, ST_EXC_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {IORD_PC = 3'd0, IORD_CAUSE = 3'd1, IORD_A = 3'd2,
                              IORD_B = 3'd3, IORD_RESULT = 3'd4} iord_e;
    typedef enum logic [1:0] {CAUSE_OPCODE = 2'd0, CAUSE_OVERFLOW = 2'd1} cause_e;
    typedef enum logic [2:0] {PCSRC_RESULT = 3'd0, PCSRC_ALUOUT = 3'd1, PCSRC_JUMP = 3'd2,
                              PCSRC_MEMBYTE = 3'd3, PCSRC_EPC = 3'd4} pcsrc_e;
    typedef enum logic [1:0] {REGDST_RT = 2'd0, REGDST_RD = 2'd1,
                              REGDST_RA = 2'd2, REGDST_SP = 2'd3} regdst_e;
    typedef enum logic [2:0] {DSRC_ALUOUT = 3'd0, DSRC_LOAD = 3'd1, DSRC_LT = 3'd4,
                              DSRC_IMM = 3'd5, DSRC_SHIFT = 3'd6, DSRC_SP_INIT = 3'd7} dsrc_e;
    typedef enum logic [1:0] {ALUA_PC = 2'd0, ALUA_MEM = 2'd1, ALUA_A = 2'd2} alua_e;
    typedef enum logic [1:0] {ALUB_B = 2'd0, ALUB_FOUR = 2'd1,
                              ALUB_IMM = 2'd2, ALUB_IMM_SL2 = 2'd3} alub_e;
    typedef enum logic [2:0] {ALU_PASS = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010,
                              ALU_AND = 3'b011, ALU_CMP = 3'b111} aluop_e;
    typedef enum logic [1:0] {LS_HALF = 2'd0, LS_BYTE = 2'd1, LS_WORD = 2'd2} lsize_e;
    typedef enum logic [2:0] {SH_NOP = 3'b000, SH_LOAD = 3'b001, SH_SLL = 3'b010,
                              SH_SRL = 3'b011, SH_SRA = 3'b100} shop_e;
    typedef enum logic [1:0] {SAMT_B = 2'd0, SAMT_16 = 2'd1, SAMT_SHAMT = 2'd2} samt_e;
    typedef enum logic [1:0] {SSRC_A = 2'd0, SSRC_IMM = 2'd1, SSRC_B = 2'd2} ssrc_e;

    typedef struct packed {
        logic    pc_write;
        logic    ir_write;
        logic    write_reg;
        logic    wr_a;
        logic    wr_b;
        logic    alu_out_ctrl;
        logic    write_epc;
        logic    mem_data_reg_wr;
        logic    wr_mem;
        iord_e   iord;
        cause_e  cause;
        pcsrc_e  pc_source;
        regdst_e reg_dst;
        dsrc_e   data_src;
        alua_e   alu_a;
        alub_e   alu_b;
        aluop_e  alu_op;
        lsize_e  load_ctl;
        lsize_e  store_ctl;
        shop_e   shift;
        samt_e   shamt;
        ssrc_e   shift_src;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/control_decode.sv
// ============================================================================
// Module      : control_decode
// Description : Maps OpCode/Funct to the first post-DECODE state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_decode import control_pkg::*; (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output state_t     dispatch,
    output logic       illegal
);

    always_comb begin
        dispatch = ST_EXC_SAVE;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:                 dispatch = ST_EX_ADD;
                    FN_SUB:                 dispatch = ST_EX_SUB;
                    FN_AND:                 dispatch = ST_EX_AND;
                    FN_SLT:                 dispatch = ST_EX_SLT;
                    FN_SLL, FN_SRL, FN_SRA: dispatch = ST_SH_LD;
                    FN_JR:                  dispatch = ST_JR;
                    default:                illegal  = 1'b1;
                endcase
            end
            OP_J:                      dispatch = ST_J;
            OP_JAL:                    dispatch = ST_JAL_LINK;
            OP_BEQ:                    dispatch = ST_BEQ;
            OP_BNE:                    dispatch = ST_BNE;
            OP_ADDI:                   dispatch = ST_EX_ADDI;
            OP_LUI:                    dispatch = ST_LUI;
            OP_LB, OP_LW, OP_SB, OP_SW: dispatch = ST_ADDR;
            default:                   illegal  = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : Multicycle FSM sequencing the MIPS datapath, with exceptions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit import control_pkg::*; #(
    parameter int MEM_WAIT = 2,
    parameter int SP_INIT  = 227
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       Overflow,
    input  logic       Zero,
    input  logic       LT,
    output logic       PCWrite,
    output logic       IR_write,
    output logic       WriteReg,
    output logic       WR_A,
    output logic       WR_B,
    output logic       AluOutCtrl,
    output logic       WriteEPC,
    output logic       MemDataRegWR,
    output logic       WRmem,
    output logic [2:0] IorD,
    output logic [1:0] cause_control,
    output logic [2:0] PCSource_control,
    output logic [1:0] RegDst_control,
    output logic [2:0] DataSrc_control,
    output logic [1:0] AluA_control,
    output logic [1:0] AluB_control,
    output logic [2:0] ALU_op,
    output logic [1:0] load_control,
    output logic [1:0] Store_control,
    output logic [2:0] Shift_Control,
    output logic [1:0] Control_ShiftAmt,
    output logic [1:0] Control_mux_ShiftSrc
);

    localparam int             CNT_W        = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MEM_WAIT);
    localparam logic [7:0]     SP_INIT_BYTE = 8'(SP_INIT);

    state_t           state, state_next, dispatch;
    cause_e           cause, cause_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last, illegal;
    ctrl_t            ctrl;

    // LT reaches the slt mux and SP_INIT the constant mux inside the datapath;
    // neither influences sequencing.
    logic unused_inputs;
    assign unused_inputs = ^{LT, SP_INIT_BYTE};

    assign cnt_last = (cnt == CNT_LAST);

    control_decode u_decode (
        .opcode   (OpCode),
        .funct    (Funct),
        .dispatch (dispatch),
        .illegal  (illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RESET;
            cnt   <= '0;
            cause <= CAUSE_OPCODE;
        end else begin
            state <= state_next;
            cause <= cause_next;
            if (state_next != state)
                cnt <= '0;
            else if (!cnt_last)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        cause_next = cause;
        case (state)
            ST_RESET:  state_next = ST_FETCH;
            ST_FETCH:  if (cnt_last) state_next = ST_DECODE;
            ST_DECODE: begin
                state_next = dispatch;
                if (illegal) cause_next = CAUSE_OPCODE;
            end
            ST_EX_ADD, ST_EX_SUB, ST_EX_ADDI: begin
                if (Overflow) begin
                    state_next = ST_EXC_SAVE;
                    cause_next = CAUSE_OVERFLOW;
                end else begin
                    state_next = (state == ST_EX_ADDI) ? ST_WB_RT : ST_WB_RD;
                end
            end
            ST_EX_AND:   state_next = ST_WB_RD;
            ST_EX_SLT:   state_next = ST_WB_SLT;
            ST_SH_LD: begin
                case (Funct)
                    FN_SRL:  state_next = ST_SH_SRL;
                    FN_SRA:  state_next = ST_SH_SRA;
                    default: state_next = ST_SH_SLL;
                endcase
            end
            ST_SH_SLL, ST_SH_SRL, ST_SH_SRA: state_next = ST_WB_SH;
            ST_JAL_LINK: state_next = ST_JAL_JUMP;
            ST_ADDR:     state_next = ST_MEMRD;
            ST_MEMRD: begin
                if (cnt_last) begin
                    case (OpCode)
                        OP_LW:   state_next = ST_WB_LW;
                        OP_LB:   state_next = ST_WB_LB;
                        OP_SW:   state_next = ST_MEM_SW;
                        default: state_next = ST_MEM_SB;
                    endcase
                end
            end
            ST_EXC_SAVE: state_next = ST_EXC_READ;
            ST_EXC_READ: if (cnt_last) state_next = ST_EXC_JUMP;
            ST_WB_RD, ST_WB_SLT, ST_WB_RT, ST_LUI, ST_WB_SH, ST_JR, ST_BEQ, ST_BNE,
            ST_J, ST_JAL_JUMP, ST_WB_LW, ST_WB_LB, ST_MEM_SW, ST_MEM_SB,
            ST_EXC_JUMP: state_next = ST_FETCH;
            default:     state_next = ST_RESET;
        endcase
    end

    // Reset gates every output so an aborted instruction cannot write anything.
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state)
                ST_RESET: begin
                    ctrl.write_reg = 1'b1;
                    ctrl.reg_dst   = REGDST_SP;
                    ctrl.data_src  = DSRC_SP_INIT;
                end
                ST_FETCH: begin
                    if (cnt == '0) begin
                        ctrl.iord      = IORD_PC;
                        ctrl.alu_a     = ALUA_PC;
                        ctrl.alu_b     = ALUB_FOUR;
                        ctrl.alu_op    = ALU_ADD;
                        ctrl.pc_source = PCSRC_RESULT;
                        ctrl.pc_write  = 1'b1;
                    end
                    ctrl.ir_write = cnt_last;
                end
                ST_DECODE: begin
                    ctrl.wr_a         = 1'b1;
                    ctrl.wr_b         = 1'b1;
                    ctrl.alu_a        = ALUA_PC;
                    ctrl.alu_b        = ALUB_IMM_SL2;
                    ctrl.alu_op       = ALU_ADD;
                    ctrl.alu_out_ctrl = 1'b1;
                end
                ST_EX_ADD, ST_EX_SUB, ST_EX_AND, ST_EX_SLT: begin
                    ctrl.alu_a        = ALUA_A;
                    ctrl.alu_b        = ALUB_B;
                    ctrl.alu_out_ctrl = 1'b1;
                    case (state)
                        ST_EX_SUB: ctrl.alu_op = ALU_SUB;
                        ST_EX_AND: ctrl.alu_op = ALU_AND;
                        ST_EX_SLT: ctrl.alu_op = ALU_CMP;
                        default:   ctrl.alu_op = ALU_ADD;
                    endcase
                end
                ST_EX_ADDI, ST_ADDR: begin
                    ctrl.alu_a        = ALUA_A;
                    ctrl.alu_b        = ALUB_IMM;
                    ctrl.alu_op       = ALU_ADD;
                    ctrl.alu_out_ctrl = 1'b1;
                end
                ST_WB_RD: begin
                    ctrl.write_reg = 1'b1;
                    ctrl.reg_dst   = REGDST_RD;
                    ctrl.data_src  = DSRC_ALUOUT;
                end
                ST_WB_SLT: begin
                    ctrl.write_reg = 1'b1;
                    ctrl.reg_dst   = REGDST_RD;
                    ctrl.data_src  = DSRC_LT;
                end
                ST_WB_RT: begin
                    ctrl.write_reg = 1'b1;
                    ctrl.reg_dst   = REGDST_RT;
                    ctrl.data_src  = DSRC_ALUOUT;
                end
                ST_LUI: begin
                    ctrl.write_reg = 1'b1;
                    ctrl.reg_dst   = REGDST_RT;
                    ctrl.data_src  = DSRC_IMM;
                end
                ST_SH_LD: begin
                    ctrl.shift_src = SSRC_B;
                    ctrl.shift     = SH_LOAD;
                end
                ST_SH_SLL: begin ctrl.shamt = SAMT_SHAMT; ctrl.shift = SH_SLL; end
                ST_SH_SRL: begin ctrl.shamt = SAMT_SHAMT; ctrl.shift = SH_SRL; end
                ST_SH_SRA: begin ctrl.shamt = SAMT_SHAMT; ctrl.shift = SH_SRA; end
                ST_WB_SH: begin
                    ctrl.write_reg = 1'b1;
                    ctrl.reg_dst   = REGDST_RD;
                    ctrl.data_src  = DSRC_SHIFT;
                end
                ST_JR: begin
                    ctrl.alu_a     = ALUA_A;
                    ctrl.alu_op    = ALU_PASS;
                    ctrl.pc_source = PCSRC_RESULT;
                    ctrl.pc_write  = 1'b1;
                end
                ST_BEQ, ST_BNE: begin
                    ctrl.alu_a    = ALUA_A;
                    ctrl.alu_b    = ALUB_B;
                    ctrl.alu_op   = ALU_SUB;
                    ctrl.pc_write = (state == ST_BEQ) ? Zero : !Zero;
                    if (ctrl.pc_write) ctrl.pc_source = PCSRC_ALUOUT;
                end
                ST_J, ST_JAL_JUMP: begin
                    ctrl.pc_source = PCSRC_JUMP;
                    ctrl.pc_write  = 1'b1;
                end
                ST_JAL_LINK: begin
                    ctrl.write_reg    = 1'b1;
                    ctrl.reg_dst      = REGDST_RA;
                    ctrl.data_src     = DSRC_ALUOUT;
                    ctrl.alu_a        = ALUA_PC;
                    ctrl.alu_op       = ALU_PASS;
                    ctrl.alu_out_ctrl = 1'b1;
                end
                ST_MEMRD: begin
                    ctrl.iord            = IORD_RESULT;
                    ctrl.mem_data_reg_wr = cnt_last;
                end
                ST_WB_LW, ST_WB_LB: begin
                    ctrl.write_reg = 1'b1;
                    ctrl.reg_dst   = REGDST_RT;
                    ctrl.data_src  = DSRC_LOAD;
                    ctrl.load_ctl  = (state == ST_WB_LW) ? LS_WORD : LS_BYTE;
                end
                ST_MEM_SW, ST_MEM_SB: begin
                    ctrl.iord      = IORD_RESULT;
                    ctrl.wr_mem    = 1'b1;
                    ctrl.store_ctl = (state == ST_MEM_SW) ? LS_WORD : LS_BYTE;
                end
                ST_EXC_SAVE: begin
                    ctrl.alu_a     = ALUA_PC;
                    ctrl.alu_b     = ALUB_FOUR;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.write_epc = 1'b1;
                    ctrl.cause     = cause;
                end
                ST_EXC_READ: begin
                    ctrl.iord            = IORD_CAUSE;
                    ctrl.cause           = cause;
                    ctrl.mem_data_reg_wr = cnt_last;
                end
                ST_EXC_JUMP: begin
                    ctrl.pc_source = PCSRC_MEMBYTE;
                    ctrl.pc_write  = 1'b1;
                    ctrl.cause     = cause;
                end
                default: ;
            endcase
        end
    end

    assign PCWrite              = ctrl.pc_write;
    assign IR_write             = ctrl.ir_write;
    assign WriteReg             = ctrl.write_reg;
    assign WR_A                 = ctrl.wr_a;
    assign WR_B                 = ctrl.wr_b;
    assign AluOutCtrl           = ctrl.alu_out_ctrl;
    assign WriteEPC             = ctrl.write_epc;
    assign MemDataRegWR         = ctrl.mem_data_reg_wr;
    assign WRmem                = ctrl.wr_mem;
    assign IorD                 = ctrl.iord;
    assign cause_control        = ctrl.cause;
    assign PCSource_control     = ctrl.pc_source;
    assign RegDst_control       = ctrl.reg_dst;
    assign DataSrc_control      = ctrl.data_src;
    assign AluA_control         = ctrl.alu_a;
    assign AluB_control         = ctrl.alu_b;
    assign ALU_op               = ctrl.alu_op;
    assign load_control         = ctrl.load_ctl;
    assign Store_control        = ctrl.store_ctl;
    assign Shift_Control        = ctrl.shift;
    assign Control_ShiftAmt     = ctrl.shamt;
    assign Control_mux_ShiftSrc = ctrl.shift_src;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Cycle-by-cycle output check of control_unit against an
//               instruction-level model of its control sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    localparam int MEM_WAIT = 2;

    typedef struct packed {
        logic       pc_write, ir_write, write_reg, wr_a, wr_b;
        logic       alu_out_ctrl, write_epc, mem_data_reg_wr, wr_mem;
        logic [2:0] iord;
        logic [1:0] cause;
        logic [2:0] pc_source;
        logic [1:0] reg_dst;
        logic [2:0] data_src;
        logic [1:0] alu_a, alu_b;
        logic [2:0] alu_op;
        logic [1:0] load_ctl, store_ctl;
        logic [2:0] shift_ctl;
        logic [1:0] shamt, shift_src;
    } vec_t;

    logic       clk, reset, Overflow, Zero, LT;
    logic [5:0] OpCode, Funct;
    logic       PCWrite, IR_write, WriteReg, WR_A, WR_B, AluOutCtrl, WriteEPC, MemDataRegWR, WRmem;
    logic [2:0] IorD, PCSource_control, DataSrc_control, ALU_op, Shift_Control;
    logic [1:0] cause_control, RegDst_control, AluA_control, AluB_control;
    logic [1:0] load_control, Store_control, Control_ShiftAmt, Control_mux_ShiftSrc;

    int   tests = 0;
    int   fails = 0;
    vec_t exp_q[$];

    control_unit #(.MEM_WAIT(MEM_WAIT), .SP_INIT(227)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
        .Overflow(Overflow), .Zero(Zero), .LT(LT),
        .PCWrite(PCWrite), .IR_write(IR_write), .WriteReg(WriteReg),
        .WR_A(WR_A), .WR_B(WR_B), .AluOutCtrl(AluOutCtrl), .WriteEPC(WriteEPC),
        .MemDataRegWR(MemDataRegWR), .WRmem(WRmem), .IorD(IorD),
        .cause_control(cause_control), .PCSource_control(PCSource_control),
        .RegDst_control(RegDst_control), .DataSrc_control(DataSrc_control),
        .AluA_control(AluA_control), .AluB_control(AluB_control), .ALU_op(ALU_op),
        .load_control(load_control), .Store_control(Store_control),
        .Shift_Control(Shift_Control), .Control_ShiftAmt(Control_ShiftAmt),
        .Control_mux_ShiftSrc(Control_mux_ShiftSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t sample();
        vec_t v;
        v = '{PCWrite, IR_write, WriteReg, WR_A, WR_B, AluOutCtrl, WriteEPC, MemDataRegWR, WRmem,
              IorD, cause_control, PCSource_control, RegDst_control, DataSrc_control,
              AluA_control, AluB_control, ALU_op, load_control, Store_control,
              Shift_Control, Control_ShiftAmt, Control_mux_ShiftSrc};
        return v;
    endfunction

    task automatic check(input string tag, input int idx, input vec_t e);
        vec_t o;
        o = sample();
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, idx, o, e);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    function automatic void model_exc(input logic [1:0] c);
        vec_t e;
        e = '0; e.alu_b = 2'd1; e.alu_op = 3'b010; e.write_epc = 1'b1; e.cause = c;
        exp_q.push_back(e);
        for (int i = 0; i <= MEM_WAIT; i++) begin
            e = '0; e.iord = 3'd1; e.cause = c; e.mem_data_reg_wr = (i == MEM_WAIT);
            exp_q.push_back(e);
        end
        e = '0; e.pc_source = 3'd3; e.pc_write = 1'b1; e.cause = c;
        exp_q.push_back(e);
    endfunction

    function automatic void model_instr(input logic [5:0] op, input logic [5:0] fn,
                                        input logic ovf, input logic zero);
        vec_t e;
        logic taken;
        exp_q.delete();
        for (int i = 0; i <= MEM_WAIT; i++) begin
            e = '0;
            if (i == 0) begin e.alu_b = 2'd1; e.alu_op = 3'b001; e.pc_write = 1'b1; end
            e.ir_write = (i == MEM_WAIT);
            exp_q.push_back(e);
        end
        e = '0; e.wr_a = 1'b1; e.wr_b = 1'b1; e.alu_b = 2'd3; e.alu_op = 3'b001; e.alu_out_ctrl = 1'b1;
        exp_q.push_back(e);
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h22, 6'h24, 6'h2A: begin
                    e = '0; e.alu_a = 2'd2; e.alu_out_ctrl = 1'b1;
                    e.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 :
                               (fn == 6'h24) ? 3'b011 : 3'b111;
                    exp_q.push_back(e);
                    if (ovf && (fn == 6'h20 || fn == 6'h22)) model_exc(2'd1);
                    else begin
                        e = '0; e.write_reg = 1'b1; e.reg_dst = 2'd1;
                        e.data_src = (fn == 6'h2A) ? 3'd4 : 3'd0;
                        exp_q.push_back(e);
                    end
                end
                6'h00, 6'h02, 6'h03: begin
                    e = '0; e.shift_src = 2'd2; e.shift_ctl = 3'b001; exp_q.push_back(e);
                    e = '0; e.shamt = 2'd2;
                    e.shift_ctl = (fn == 6'h00) ? 3'b010 : (fn == 6'h02) ? 3'b011 : 3'b100;
                    exp_q.push_back(e);
                    e = '0; e.write_reg = 1'b1; e.reg_dst = 2'd1; e.data_src = 3'd6; exp_q.push_back(e);
                end
                6'h08: begin
                    e = '0; e.alu_a = 2'd2; e.pc_write = 1'b1; exp_q.push_back(e);
                end
                default: model_exc(2'd0);
            endcase
        end else begin
            case (op)
                6'h02: begin e = '0; e.pc_source = 3'd2; e.pc_write = 1'b1; exp_q.push_back(e); end
                6'h03: begin
                    e = '0; e.write_reg = 1'b1; e.reg_dst = 2'd2; e.alu_out_ctrl = 1'b1;
                    exp_q.push_back(e);
                    e = '0; e.pc_source = 3'd2; e.pc_write = 1'b1; exp_q.push_back(e);
                end
                6'h04, 6'h05: begin
                    taken = (op == 6'h04) ? zero : !zero;
                    e = '0; e.alu_a = 2'd2; e.alu_op = 3'b010; e.pc_write = taken;
                    e.pc_source = taken ? 3'd1 : 3'd0;
                    exp_q.push_back(e);
                end
                6'h08: begin
                    e = '0; e.alu_a = 2'd2; e.alu_b = 2'd2; e.alu_op = 3'b001; e.alu_out_ctrl = 1'b1;
                    exp_q.push_back(e);
                    if (ovf) model_exc(2'd1);
                    else begin e = '0; e.write_reg = 1'b1; exp_q.push_back(e); end
                end
                6'h0F: begin e = '0; e.write_reg = 1'b1; e.data_src = 3'd5; exp_q.push_back(e); end
                6'h20, 6'h23, 6'h28, 6'h2B: begin
                    e = '0; e.alu_a = 2'd2; e.alu_b = 2'd2; e.alu_op = 3'b001; e.alu_out_ctrl = 1'b1;
                    exp_q.push_back(e);
                    for (int i = 0; i <= MEM_WAIT; i++) begin
                        e = '0; e.iord = 3'd4; e.mem_data_reg_wr = (i == MEM_WAIT); exp_q.push_back(e);
                    end
                    e = '0;
                    if (op == 6'h23 || op == 6'h20) begin
                        e.write_reg = 1'b1; e.data_src = 3'd1;
                        e.load_ctl = (op == 6'h23) ? 2'd2 : 2'd1;
                    end else begin
                        e.iord = 3'd4; e.wr_mem = 1'b1;
                        e.store_ctl = (op == 6'h2B) ? 2'd2 : 2'd1;
                    end
                    exp_q.push_back(e);
                end
                default: model_exc(2'd0);
            endcase
        end
    endfunction

    // Entered at a falling edge with the DUT in the first FETCH cycle.
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic ovf, input logic zero, input int limit);
        int n;
        OpCode = op; Funct = fn; Overflow = ovf; Zero = zero; LT = 1'($urandom);
        model_instr(op, fn, ovf, zero);
        n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            #1 check(tag, n, exp_q.pop_front());
            n++;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset(input string tag, input int cycles);
        vec_t sp;
        sp = '0; sp.write_reg = 1'b1; sp.reg_dst = 2'd3; sp.data_src = 3'd7;
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            OpCode = 6'($urandom); Funct = 6'($urandom);
            #1 check({tag, "_held"}, i, '0);
            @(negedge clk);
        end
        reset = 1'b0;
        #1 check({tag, "_sp"}, 0, sp);
        @(negedge clk);
    endtask

    localparam logic [5:0] LEGAL_OPS [11] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                              6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B};
    localparam logic [5:0] R_FUNCTS [8] = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h08};

    initial begin
        logic [5:0] op, fn;
        int sel;
        reset = 1'b1; OpCode = '0; Funct = '0; Overflow = 1'b0; Zero = 1'b0; LT = 1'b0;
        apply_reset("por", 3);

        run("add",      6'h00, 6'h20, 1'b0, 1'b0, 99);
        run("lw",       6'h23, 6'h11, 1'b0, 1'b0, 99);
        run("beq_t",    6'h04, 6'h05, 1'b0, 1'b1, 99);
        run("beq_nt",   6'h04, 6'h05, 1'b0, 1'b0, 99);
        run("bne_t",    6'h05, 6'h05, 1'b0, 1'b0, 99);
        run("bne_nt",   6'h05, 6'h05, 1'b0, 1'b1, 99);
        run("add_ovf",  6'h00, 6'h20, 1'b1, 1'b0, 99);
        run("sra",      6'h00, 6'h03, 1'b0, 1'b0, 99);
        run("sb",       6'h28, 6'h00, 1'b0, 1'b0, 99);
        run("illegal",  6'h3F, 6'h00, 1'b0, 1'b0, 99);
        // Stop partway into EXC_READ, then assert reset there.
        run("abort",    6'h3F, 6'h00, 1'b0, 1'b0, MEM_WAIT + 4);
        apply_reset("mid", 2);
        run("after_rst", 6'h08, 6'h00, 1'b1, 1'b0, 99);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 11);
            op  = (sel == 11) ? 6'($urandom) : LEGAL_OPS[sel];
            sel = $urandom_range(0, 8);
            fn  = (sel == 8) ? 6'($urandom) : R_FUNCTS[sel];
            run($sformatf("rnd%0d_op%02h_fn%02h", i, op, fn), op, fn,
                1'($urandom), 1'($urandom), 99);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
